// File: rtl/multicycle_core.sv
// multicycle_core: FETCH/DECODE/EXEC/MEM/WB RISC core with req/ready memories.
// Define CORE_MUL_EN to enable opcode 10 (MUL), which takes a two-cycle EXEC.
module multicycle_core #(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            Clk,
    input  logic            Rst,
    output logic            Imem_Req,
    output logic [XLEN-1:0] Imem_Addr,
    input  logic            Imem_Ready,
    input  logic [31:0]     Imem_Rdata,
    output logic            Dmem_Req,
    output logic            Dmem_We,
    output logic [XLEN-1:0] Dmem_Addr,
    output logic [XLEN-1:0] Dmem_Wdata,
    input  logic            Dmem_Ready,
    input  logic [XLEN-1:0] Dmem_Rdata,
    output logic            Retire,
    output logic            Halted,
    output logic            Illegal
);
    localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_LW   = 4'd6;
    localparam logic [3:0] OP_SW   = 4'd7;
    localparam logic [3:0] OP_BEQ  = 4'd8;
    localparam logic [3:0] OP_J    = 4'd9;
    localparam logic [3:0] OP_HALT = 4'd15;
`ifdef CORE_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'd10;
`endif

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_ir;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_alu;
    logic [XLEN-1:0] r_mdr;
    logic            r_illegal;
    logic [XLEN-1:0] r_rf [NREGS];

    logic [3:0]      w_op;
    logic [4:0]      w_rs;
    logic [4:0]      w_rt;
    logic [4:0]      w_rd;
    logic [4:0]      w_dst;
    logic [XLEN-1:0] w_rs_val;
    logic [XLEN-1:0] w_rt_val;
    logic [XLEN-1:0] w_alu;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_pc4;
    logic [XLEN-1:0] w_pc_next;
    logic            w_is_rtype;
    logic            w_legal;
    logic            w_mul_wait;
    logic            w_mul_op;
    logic            w_retire;
    logic            w_mem;
    logic            w_unused;

    assign w_op = r_ir[31:28];
    assign w_rs = r_ir[25:21];
    assign w_rt = r_ir[20:16];
    assign w_rd = r_ir[15:11];
    assign w_unused = &{1'b0, r_ir[27:26], r_imm[XLEN-1:XLEN-2]};

`ifdef CORE_MUL_EN
    logic            r_mul_ph;
    logic [XLEN-1:0] w_prod;
    assign w_prod     = r_a * r_b;
    assign w_mul_op   = (w_op == OP_MUL);
    assign w_mul_wait = w_mul_op && !r_mul_ph;
`else
    assign w_mul_op   = 1'b0;
    assign w_mul_wait = 1'b0;
`endif

    // Index 0 and indices beyond NREGS are hard-wired to zero.
    always_comb begin
        w_rs_val = '0;
        w_rt_val = '0;
        if (w_rs != 5'd0 && int'(w_rs) < NREGS) w_rs_val = r_rf[w_rs[RW-1:0]];
        if (w_rt != 5'd0 && int'(w_rt) < NREGS) w_rt_val = r_rf[w_rt[RW-1:0]];
    end

    always_comb begin
        w_is_rtype = 1'b0;
        w_legal    = 1'b1;
        case (w_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: w_is_rtype = 1'b1;
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_HALT: w_legal = 1'b1;
`ifdef CORE_MUL_EN
            OP_MUL: w_is_rtype = 1'b1;
`endif
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_ADD: w_alu = r_a + r_b;
            OP_SUB: w_alu = r_a - r_b;
            OP_AND: w_alu = r_a & r_b;
            OP_OR:  w_alu = r_a | r_b;
            OP_SLT: w_alu = {{(XLEN-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
            OP_ADDI, OP_LW, OP_SW: w_alu = r_a + r_imm;
`ifdef CORE_MUL_EN
            OP_MUL: w_alu = w_prod;
`endif
            default: w_alu = '0;
        endcase
    end

    assign w_pc4 = r_pc + XLEN'(4);

    always_comb begin
        w_pc_next = w_pc4;
        if (w_op == OP_BEQ && r_a == r_b)
            w_pc_next = w_pc4 + {r_imm[XLEN-3:0], 2'b00};
        else if (w_op == OP_J)
            w_pc_next = {{(XLEN-28){1'b0}}, r_ir[25:0], 2'b00};
    end

    assign w_dst   = w_is_rtype ? w_rd : w_rt;
    assign w_wdata = (w_op == OP_LW) ? r_mdr : r_alu;

    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        unique case (r_state)
            S_FETCH:  if (Imem_Ready) w_next = S_DECODE;
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                if (!w_legal || w_op == OP_HALT) begin
                    w_next = S_HALT;
                end else if (w_mul_wait) begin
                    w_next = S_EXEC;
                end else if (w_op == OP_LW || w_op == OP_SW) begin
                    w_next = S_MEM;
                end else if (w_op == OP_BEQ || w_op == OP_J) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                if (Dmem_Ready) begin
                    w_next   = (w_op == OP_LW) ? S_WB : S_FETCH;
                    w_retire = (w_op == OP_SW);
                end
            end
            S_WB: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_HALT;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_imm     <= '0;
            r_alu     <= '0;
            r_mdr     <= '0;
            r_illegal <= 1'b0;
`ifdef CORE_MUL_EN
            r_mul_ph  <= 1'b0;
`endif
            for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_FETCH: if (Imem_Ready) r_ir <= Imem_Rdata;
                S_DECODE: begin
                    r_a   <= w_rs_val;
                    r_b   <= w_rt_val;
                    r_imm <= {{(XLEN-16){r_ir[15]}}, r_ir[15:0]};
                end
                S_EXEC: begin
                    if (!w_legal) r_illegal <= 1'b1;
                    // MUL: product lands in the first cycle, PC moves in the second.
                    if (w_mul_wait) begin
                        r_alu <= w_alu;
`ifdef CORE_MUL_EN
                        r_mul_ph <= 1'b1;
`endif
                    end else begin
                        if (!w_mul_op) r_alu <= w_alu;
                        r_pc <= w_pc_next;
`ifdef CORE_MUL_EN
                        r_mul_ph <= 1'b0;
`endif
                    end
                end
                S_MEM: if (Dmem_Ready && w_op == OP_LW) r_mdr <= Dmem_Rdata;
                S_WB: begin
                    if (w_dst != 5'd0 && int'(w_dst) < NREGS)
                        r_rf[w_dst[RW-1:0]] <= w_wdata;
                end
                default: ;
            endcase
        end
    end

    assign w_mem      = (r_state == S_MEM);
    assign Imem_Req   = (r_state == S_FETCH) && !Rst;
    assign Imem_Addr  = r_pc;
    assign Dmem_Req   = w_mem;
    assign Dmem_We    = w_mem && (w_op == OP_SW);
    assign Dmem_Addr  = w_mem ? r_alu : '0;
    assign Dmem_Wdata = w_mem ? r_b : '0;
    assign Retire     = w_retire && !Rst;
    assign Halted     = (r_state == S_HALT);
    assign Illegal    = r_illegal;
endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: wait-stated memory models and
// hand-computed cycle/value expectations.
module tb_multicycle_core;
    localparam int XLEN = 32;

    logic            Clk = 1'b0;
    logic            Rst = 1'b1;
    logic            Imem_Req;
    logic [XLEN-1:0] Imem_Addr;
    logic            Imem_Ready;
    logic [31:0]     Imem_Rdata;
    logic            Dmem_Req;
    logic            Dmem_We;
    logic [XLEN-1:0] Dmem_Addr;
    logic [XLEN-1:0] Dmem_Wdata;
    logic            Dmem_Ready;
    logic [XLEN-1:0] Dmem_Rdata;
    logic            Retire;
    logic            Halted;
    logic            Illegal;

    logic [31:0] imem [0:511];
    logic [31:0] dmem [0:255];
    int iwait = 0;
    int dwait = 0;
    int icnt = 0;
    int dcnt = 0;
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    multicycle_core #(
        .XLEN(XLEN),
        .NREGS(8),
        .RESET_PC(32'h0)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .Imem_Req(Imem_Req),
        .Imem_Addr(Imem_Addr),
        .Imem_Ready(Imem_Ready),
        .Imem_Rdata(Imem_Rdata),
        .Dmem_Req(Dmem_Req),
        .Dmem_We(Dmem_We),
        .Dmem_Addr(Dmem_Addr),
        .Dmem_Wdata(Dmem_Wdata),
        .Dmem_Ready(Dmem_Ready),
        .Dmem_Rdata(Dmem_Rdata),
        .Retire(Retire),
        .Halted(Halted),
        .Illegal(Illegal)
    );

    assign Imem_Ready = Imem_Req && (icnt >= iwait);
    assign Imem_Rdata = imem[Imem_Addr[10:2]];
    assign Dmem_Ready = Dmem_Req && (dcnt >= dwait);
    assign Dmem_Rdata = dmem[Dmem_Addr[9:2]];

    always @(posedge Clk) begin
        icnt <= (Imem_Req && !Imem_Ready) ? icnt + 1 : 0;
        dcnt <= (Dmem_Req && !Dmem_Ready) ? dcnt + 1 : 0;
        if (Rst) begin
            for (int i = 0; i < 256; i++) dmem[i] <= 32'hDEADBEEF;
        end else if (Dmem_Req && Dmem_We && Dmem_Ready) begin
            dmem[Dmem_Addr[9:2]] <= Dmem_Wdata;
        end
    end

    function automatic logic [31:0] enc_r(input logic [3:0] op,
            input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {op, 2'b00, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [3:0] op,
            input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, 2'b00, rs, rt, imm};
    endfunction

    localparam logic [31:0] HALTW = 32'hF000_0000;

    task automatic chk(input string tag, input logic [63:0] obs,
            input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 512; i++) imem[i] = HALTW;
    endtask

    task automatic reset_core();
        Rst = 1'b1;
        step();
        step();
        chk("reset_ctrl", {Imem_Req, Dmem_Req, Dmem_We, Retire, Halted, Illegal}, 0);
        chk("reset_iaddr", Imem_Addr, 0);
        chk("reset_daddr", {Dmem_Addr, Dmem_Wdata}, 0);
        Rst = 1'b0;
        #1;
        cyc = 1;
    endtask

    task automatic run_halt(input string tag, input int maxc);
        while (!Halted && cyc < maxc) step();
        chk(tag, Halted, 1);
    endtask

    int nret;

    initial begin
        // ALU sequence and retire timing
        clear_prog();
        imem[0] = enc_i(4'd5, 5'd0, 5'd1, 16'd5);
        imem[1] = enc_i(4'd5, 5'd0, 5'd2, 16'd7);
        imem[2] = enc_r(4'd0, 5'd1, 5'd2, 5'd3);
        reset_core();
        chk("t1_first_req", Imem_Req, 1);
        chk("t1_first_addr", Imem_Addr, 0);
        for (int c = 1; c <= 16; c++) begin
            goto(c);
            chk($sformatf("t1_retire_c%0d", c), Retire, (c == 4 || c == 8 || c == 12));
            if (c == 2) chk("t1_req_drop", Imem_Req, 0);
            if (c == 15) chk("t1_not_halted", Halted, 0);
        end
        chk("t1_halted", Halted, 1);
        chk("t1_legal", Illegal, 0);

        // SW / LW with three Dmem wait states
        clear_prog();
        dwait = 3;
        imem[0] = enc_i(4'd5, 5'd0, 5'd1, 16'd5);
        imem[1] = enc_i(4'd5, 5'd0, 5'd2, 16'd7);
        imem[2] = enc_r(4'd0, 5'd1, 5'd2, 5'd3);
        imem[3] = enc_i(4'd7, 5'd0, 5'd3, 16'h40);
        imem[4] = enc_i(4'd6, 5'd0, 5'd4, 16'h40);
        imem[5] = enc_i(4'd7, 5'd0, 5'd4, 16'h44);
        reset_core();
        for (int c = 16; c <= 19; c++) begin
            goto(c);
            chk($sformatf("t2_sw_bus_c%0d", c),
                {Dmem_Req, Dmem_We, Imem_Req, Dmem_Addr, Dmem_Wdata},
                {1'b1, 1'b1, 1'b0, 32'h40, 32'd12});
            chk($sformatf("t2_sw_retire_c%0d", c), Retire, (c == 19));
        end
        for (int c = 20; c <= 27; c++) begin
            goto(c);
            chk($sformatf("t2_lw_retire_c%0d", c), Retire, (c == 27));
            if (c == 20) chk("t2_dreq_drop", {Dmem_Req, Imem_Req, Imem_Addr}, {2'b01, 32'h10});
            if (c >= 23 && c <= 26)
                chk($sformatf("t2_lw_bus_c%0d", c), {Dmem_Req, Dmem_We, Dmem_Addr},
                    {1'b1, 1'b0, 32'h40});
        end
        run_halt("t2_halt", 80);
        chk("t2_sw_data", dmem[16], 32'd12);
        chk("t2_lw_data", dmem[17], 32'd12);
        dwait = 0;

        // BEQ taken / not taken, J
        clear_prog();
        imem[0] = enc_i(4'd5, 5'd0, 5'd1, 16'd3);
        imem[1] = enc_i(4'd5, 5'd0, 5'd2, 16'd4);
        imem[2] = enc_r(4'd0, 5'd0, 5'd0, 5'd0);
        imem[3] = enc_r(4'd0, 5'd0, 5'd0, 5'd0);
        imem[4] = enc_i(4'd8, 5'd1, 5'd1, 16'd2);
        imem[7] = enc_i(4'd8, 5'd1, 5'd2, 16'd2);
        imem[8] = {4'd9, 2'b00, 26'h100};
        reset_core();
        goto(19);
        chk("t3_beq_retire", Retire, 1);
        goto(20);
        chk("t3_beq_taken", {Imem_Req, Imem_Addr}, {1'b1, 32'h1C});
        goto(22);
        chk("t3_beq_nt_retire", Retire, 1);
        goto(23);
        chk("t3_beq_not_taken", Imem_Addr, 32'h20);
        goto(25);
        chk("t3_j_retire", Retire, 1);
        goto(26);
        chk("t3_j_target", Imem_Addr, 32'h400);
        goto(29);
        chk("t3_halt_at_400", {Halted, Illegal}, 2'b10);

        imem[4] = enc_i(4'd8, 5'd1, 5'd2, 16'd2);
        reset_core();
        goto(20);
        chk("t3b_beq_nt_0x10", Imem_Addr, 32'h14);
        goto(23);
        chk("t3b_halt_at_14", Halted, 1);

        // R0 and out-of-range register behaviour (NREGS = 8)
        clear_prog();
        imem[0] = enc_i(4'd5, 5'd0, 5'd0, 16'd9);
        imem[1] = enc_r(4'd0, 5'd0, 5'd0, 5'd5);
        imem[2] = enc_i(4'd7, 5'd0, 5'd5, 16'h50);
        imem[3] = enc_i(4'd5, 5'd0, 5'd9, 16'd33);
        imem[4] = enc_i(4'd7, 5'd0, 5'd9, 16'h54);
        imem[5] = enc_i(4'd7, 5'd0, 5'd1, 16'h58);
        imem[6] = enc_i(4'd5, 5'd0, 5'd1, 16'd1);
        imem[7] = enc_r(4'd0, 5'd9, 5'd1, 5'd6);
        imem[8] = enc_i(4'd7, 5'd0, 5'd6, 16'h5C);
        reset_core();
        run_halt("t4_halt", 100);
        chk("t4_r5_zero", dmem[20], 0);
        chk("t4_r9_zero", dmem[21], 0);
        chk("t4_r1_no_alias", dmem[22], 0);
        chk("t4_r9_plus_r1", dmem[23], 1);

        // Reset during an Imem wait, then illegal opcode 12
        clear_prog();
        iwait = 3;
        imem[0] = 32'hC000_0000;
        reset_core();
        goto(2);
        chk("t5_waiting", {Imem_Req, Imem_Addr}, {1'b1, 32'h0});
        Rst = 1'b1;
        step();
        chk("t5_rst_req_drop", Imem_Req, 0);
        Rst = 1'b0;
        #1;
        cyc = 1;
        chk("t5_refetch", {Imem_Req, Imem_Addr}, {1'b1, 32'h0});
        nret = 0;
        for (int c = 1; c <= 8; c++) begin
            goto(c);
            nret += int'(Retire);
            if (c == 6) chk("t5_not_yet_halted", Halted, 0);
        end
        chk("t5_no_retire", nret, 0);
        chk("t5_illegal", {Halted, Illegal}, 2'b11);
        iwait = 0;

        // Opcode 10
        clear_prog();
        imem[0] = enc_i(4'd5, 5'd0, 5'd1, 16'd6);
        imem[1] = enc_i(4'd5, 5'd0, 5'd2, 16'd7);
        imem[2] = enc_r(4'd10, 5'd1, 5'd2, 5'd3);
        imem[3] = enc_i(4'd7, 5'd0, 5'd3, 16'h60);
        reset_core();
`ifdef CORE_MUL_EN
        goto(12);
        chk("t6_mul_no_early_retire", Retire, 0);
        goto(13);
        chk("t6_mul_retire", Retire, 1);
        run_halt("t6_halt", 60);
        chk("t6_mul_result", dmem[24], 32'd42);
        chk("t6_legal", Illegal, 0);
`else
        nret = 0;
        for (int c = 9; c <= 12; c++) begin
            goto(c);
            nret += int'(Retire);
        end
        chk("t6_no_retire", nret, 0);
        chk("t6_mul_illegal", {Halted, Illegal}, 2'b11);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_core.md
# multicycle_core

Parametrised multi-cycle successor to the team's single-cycle 32-bit RISC CPU top. It executes the same 4-bit-opcode instruction format through a FETCH/DECODE/EXEC/MEM/WB state machine, so PC, register file, ALU and memory are time-shared across cycles. Instruction and data memory sit outside the block behind req/ready handshakes, which allows wait-stated memories. It is the top-level core instantiated by the SoC wrapper and the testbench.

## Interface
Parameters:
- XLEN, 32: data/address width (32 or 64); instructions are always 32 bits.
- NREGS, 32: architectural registers, 8..32.
- RESET_PC, 0: PC loaded on reset.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  reset; synchronous and active-high.
- Imem_Req  out  1  instruction fetch request.
- Imem_Addr  out  XLEN  fetch address (current PC).
- Imem_Ready  in  1  fetch complete; Imem_Rdata is valid in the same cycle.
- Imem_Rdata  in  32  instruction word.
- Dmem_Req  out  1  data access request.
- Dmem_We  out  1  1 = store, 0 = load.
- Dmem_Addr  out  XLEN  effective address.
- Dmem_Wdata  out  XLEN  store data.
- Dmem_Ready  in  1  access complete; Dmem_Rdata is valid in the same cycle for loads.
- Dmem_Rdata  in  XLEN  load data.
- Retire  out  1  one-cycle pulse in the last cycle of each completed instruction.
- Halted  out  1  core stopped.
- Illegal  out  1  core stopped on an undefined opcode.

## Operation
- Instruction fields: op = [31:28], rs = [25:21], rt = [20:16], rd = [15:11], imm = [15:0] (sign-extended to XLEN), target = [25:0].
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT (signed; result 0 or 1): rd = rs op rt.
  - 5 ADDI: rt = rs + imm.
  - 6 LW: rt = mem[rs + imm].
  - 7 SW: mem[rs + imm] = rt.
  - 8 BEQ: if rs == rt, PC = PC + 4 + (imm << 2).
  - 9 J: PC = zero-extended target << 2.
  - 10 MUL: see Configuration.
  - 15 HALT.
  - Any other opcode sets Illegal and Halted.
- Register 0 reads as 0 and ignores writes. Register indices >= NREGS read as 0 and ignore writes.
- All arithmetic is modulo 2^XLEN. No overflow traps. Addresses are not alignment-checked.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - FETCH: hold Imem_Req = 1 with Imem_Addr = PC until Imem_Ready; latch IR; go to DECODE.
  - DECODE: latch A = R[rs], B = R[rt], and sign-extended imm.
  - EXEC: compute the ALU result into ALUOut. PC is written here:
    - PC + 4 for non-branch instructions;
    - the branch/jump target when taken.
  - EXEC next state: LW/SW go to MEM; ALU ops go to WB; BEQ/J go to FETCH; HALT or an illegal opcode goes to HALT.
  - MEM: hold Dmem_Req, Dmem_Addr = ALUOut, Dmem_We and Dmem_Wdata = B stable until Dmem_Ready. A load goes to WB with the data latched; a store goes to FETCH.
  - WB: write the register file; go to FETCH.
  - HALT: absorbing state; only Rst leaves it. Retire is not pulsed for HALT or illegal instructions.
- Retire pulses in the WB cycle (ALU ops, LW), the MEM cycle in which Dmem_Ready is high (SW), or the EXEC cycle (BEQ, J).

## Timing
- Reset values: PC = RESET_PC, state FETCH, every output 0. Registers R1..R(NREGS-1) are cleared.
- The first Imem_Req is asserted in the first cycle after Rst deasserts.
- Cycle counts at zero wait states (Ready high in the request cycle):
  - ALU ops: 4 (F, D, E, W).
  - LW: 5 (F, D, E, M, W).
  - SW: 4 (F, D, E, M).
  - BEQ/J: 3 (F, D, E).
  - Each wait cycle adds 1.
- While waiting, Req, address, We and Wdata must not change.
- Req drops in the cycle after Ready.
- Req is never asserted on both memory ports in the same cycle.
- Rst mid-transaction: Req is 0 on the next cycle and the in-flight access is abandoned. Memories must tolerate an abandoned request.
- A register write in WB is visible to the next instruction's DECODE. No hazards exist, because instructions do not overlap.

## Configuration
- CORE_MUL_EN defined: opcode 10 is MUL, rd = low XLEN bits of rs * rt. It follows the ALU path with an extra EXEC cycle, giving 5 cycles at zero wait.
- CORE_MUL_EN undefined: opcode 10 is illegal (Illegal = 1, Halted = 1) and no multiplier is synthesised.

## Test plan
- Reset then zero-wait memory running ADDI R1,R0,5; ADDI R2,R0,7; ADD R3,R1,R2; HALT -> R3 = 12, Retire pulses at cycles 4, 8, 12, Halted = 1 after 15 cycles.
- SW R3 to address 0x40, then LW R4 from 0x40, with Dmem_Ready delayed 3 cycles -> Dmem_Addr/Wdata held stable during the wait, R4 = 12, LW takes 8 cycles.
- BEQ R1,R1,+2 at PC 0x10 -> next Imem_Addr = 0x1C; BEQ with unequal operands -> next Imem_Addr = 0x14; J 0x100 -> next Imem_Addr = 0x400.
- ADDI R0,R0,9 then ADD R5,R0,R0 -> R5 = 0; with NREGS = 8, a write to R9 is ignored and a later read of R9 returns 0.
- Rst asserted during an Imem wait -> Imem_Req = 0 next cycle, then a fresh fetch at RESET_PC; opcode 12 -> Illegal = 1, Halted = 1, no Retire.
- Opcode 10 with R1 = 6, R2 = 7 -> R3 = 42 in 5 cycles with CORE_MUL_EN defined; Illegal = 1 without it.
